// File: rtl/hazard_unit_param.sv
// hazard_unit_param: forwarding, load-use stall and squash controller with a FWD_DEPTH writer table.
// Define HAZ_PERF_EN to add the perf_stall_cnt / perf_fwd_cnt counters.
module hazard_unit_param #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned NSTAGE    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_reg_write,
    input  logic [4:0]        ex_wr_addr,
    input  logic              ex_is_load,
    input  logic              ex_csr_en,
    input  logic [XLEN-1:0]   ex_alu_out,
    input  logic [XLEN-1:0]   ex_csr_out,
    input  logic [XLEN-1:0]   mem_load_data,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              redirect,
    input  logic              flush,
    output logic [XLEN-1:0]   rs1_fw,
    output logic [XLEN-1:0]   rs2_fw,
    output logic              stall_n,
    output logic [NSTAGE-1:0] squash
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_fwd_cnt
`endif
);

    typedef struct packed {
        logic            valid;
        logic [4:0]      addr;
        logic            is_load;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t            tbl [FWD_DEPTH];
    entry_t            new_entry;
    logic              rs1_hit;
    logic              rs1_haz;
    logic [XLEN-1:0]   rs1_val;
    logic              rs2_hit;
    logic              rs2_haz;
    logic [XLEN-1:0]   rs2_val;
    logic [NSTAGE-1:0] squash_nxt;

    // Entry 0 gets a bubble while stalled; squashed EX instructions never enter.
    always_comb begin
        new_entry         = '0;
        new_entry.valid   = stall_n & ex_reg_write & (ex_wr_addr != 5'd0) & ~squash[1];
        new_entry.addr    = ex_wr_addr;
        new_entry.is_load = ex_is_load & ~ex_csr_en;
        new_entry.data    = ex_csr_en ? ex_csr_out : ex_alu_out;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            tbl[0] <= new_entry;
            for (int unsigned i = 1; i < FWD_DEPTH; i++) begin
                tbl[i] <= tbl[i-1];
                // A load leaving LOAD_LAT picks up its data and becomes a plain writer.
                if ((i == LOAD_LAT + 1) && tbl[i-1].valid && tbl[i-1].is_load) begin
                    tbl[i].is_load <= 1'b0;
                    tbl[i].data    <= mem_load_data;
                end
            end
        end
    end

    always_comb begin
        rs1_hit = 1'b0;
        rs1_haz = 1'b0;
        rs1_val = rs1_data;
        for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
            if (!rs1_hit && use_rs1 && tbl[i].valid &&
                (tbl[i].addr == rs1_addr) && (rs1_addr != 5'd0)) begin
                rs1_hit = 1'b1;
                rs1_val = tbl[i].data;
                if (tbl[i].is_load) begin
                    if (i == LOAD_LAT) begin
                        rs1_val = mem_load_data;
                    end else if (i < LOAD_LAT) begin
                        rs1_haz = 1'b1;
                    end
                end
            end
        end
        if (RST) begin
            rs1_hit = 1'b0;
            rs1_haz = 1'b0;
            rs1_val = rs1_data;
        end
    end

    always_comb begin
        rs2_hit = 1'b0;
        rs2_haz = 1'b0;
        rs2_val = rs2_data;
        for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
            if (!rs2_hit && use_rs2 && tbl[i].valid &&
                (tbl[i].addr == rs2_addr) && (rs2_addr != 5'd0)) begin
                rs2_hit = 1'b1;
                rs2_val = tbl[i].data;
                if (tbl[i].is_load) begin
                    if (i == LOAD_LAT) begin
                        rs2_val = mem_load_data;
                    end else if (i < LOAD_LAT) begin
                        rs2_haz = 1'b1;
                    end
                end
            end
        end
        if (RST) begin
            rs2_hit = 1'b0;
            rs2_haz = 1'b0;
            rs2_val = rs2_data;
        end
    end

    always_comb begin
        rs1_fw  = rs1_val;
        rs2_fw  = rs2_val;
        stall_n = ~(rs1_haz | rs2_haz);
    end

    // Redirect/flush during a stall are dropped; the stalled instruction re-raises them.
    always_comb begin
        squash_nxt = squash << 1;
        if (!stall_n) begin
            squash_nxt[1:0] = squash[1:0];
            squash_nxt[2]   = 1'b1;
        end else begin
            if (redirect) begin
                squash_nxt[1:0] = 2'b11;
            end
            if (flush) begin
                squash_nxt[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            squash <= '0;
        end else begin
            squash <= squash_nxt;
        end
    end

`ifdef HAZ_PERF_EN
    logic fwd_taken;

    always_comb begin
        fwd_taken = (rs1_hit & ~rs1_haz) | (rs2_hit & ~rs2_haz);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (!stall_n) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (fwd_taken) begin
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_param.sv
// Directed bench for hazard_unit_param: default build plus a LOAD_LAT=2 / FWD_DEPTH=3 instance.
module tb_hazard_unit_param;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ex_reg_write;
    logic [4:0]  ex_wr_addr;
    logic        ex_is_load;
    logic        ex_csr_en;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_csr_out;
    logic [31:0] mem_load_data;
    logic        use_rs1;
    logic        use_rs2;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        redirect;
    logic        flush;

    logic [31:0] rs1_fw;
    logic [31:0] rs2_fw;
    logic        stall_n;
    logic [3:0]  squash;
    logic [31:0] rs1_fw_b;
    logic [31:0] rs2_fw_b;
    logic        stall_n_b;
    logic [3:0]  squash_b;
`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_fwd_cnt;
    logic [31:0] perf_stall_cnt_b;
    logic [31:0] perf_fwd_cnt_b;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 CLK = ~CLK;

    hazard_unit_param #(.XLEN(32), .FWD_DEPTH(2), .LOAD_LAT(1), .NSTAGE(4)) dut (
        .CLK(CLK), .RST(RST),
        .ex_reg_write(ex_reg_write), .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load),
        .ex_csr_en(ex_csr_en), .ex_alu_out(ex_alu_out), .ex_csr_out(ex_csr_out),
        .mem_load_data(mem_load_data), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .redirect(redirect), .flush(flush),
        .rs1_fw(rs1_fw), .rs2_fw(rs2_fw), .stall_n(stall_n), .squash(squash)
`ifdef HAZ_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
    );

    hazard_unit_param #(.XLEN(32), .FWD_DEPTH(3), .LOAD_LAT(2), .NSTAGE(4)) dut_lat2 (
        .CLK(CLK), .RST(RST),
        .ex_reg_write(ex_reg_write), .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load),
        .ex_csr_en(ex_csr_en), .ex_alu_out(ex_alu_out), .ex_csr_out(ex_csr_out),
        .mem_load_data(mem_load_data), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .redirect(redirect), .flush(flush),
        .rs1_fw(rs1_fw_b), .rs2_fw(rs2_fw_b), .stall_n(stall_n_b), .squash(squash_b)
`ifdef HAZ_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt_b), .perf_fwd_cnt(perf_fwd_cnt_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ex_reg_write  = 1'b0;
        ex_wr_addr    = 5'd0;
        ex_is_load    = 1'b0;
        ex_csr_en     = 1'b0;
        ex_alu_out    = '0;
        ex_csr_out    = '0;
        mem_load_data = 32'h5A5A5A5A;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        rs1_addr      = 5'd0;
        rs2_addr      = 5'd0;
        rs1_data      = 32'hA1A1A1A1;
        rs2_data      = 32'hB2B2B2B2;
        redirect      = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] val);
        ex_reg_write = 1'b1;
        ex_wr_addr   = addr;
        ex_alu_out   = val;
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    initial begin
        idle();
        RST = 1'b1;
        use_rs1 = 1'b1; rs1_addr = 5'd5;
        next();
        mid();
        check("reset_squash", {28'd0, squash}, 32'h0);
        check("reset_stall_n", {31'd0, stall_n}, 32'h1);
        check("reset_rs1_pass", rs1_fw, 32'hA1A1A1A1);
        next();
        RST = 1'b0;

        // ALU chain, then CSR result forwarding
        idle(); wr(5'd5, 32'h00001234);
        next();
        idle(); use_rs1 = 1'b1; rs1_addr = 5'd5;
        wr(5'd9, 32'h00001111); ex_csr_en = 1'b1; ex_csr_out = 32'h0000C5C5;
        mid();
        check("alu_fwd", rs1_fw, 32'h00001234);
        check("alu_stall_n", {31'd0, stall_n}, 32'h1);
        next();
        idle(); use_rs1 = 1'b1; rs1_addr = 5'd5; use_rs2 = 1'b1; rs2_addr = 5'd9;
        mid();
        check("csr_fwd", rs2_fw, 32'h0000C5C5);
        check("entry1_fwd", rs1_fw, 32'h00001234);
        next();

        // youngest writer wins, then ages out
        idle(); wr(5'd7, 32'h1);
        next();
        idle(); wr(5'd7, 32'h2);
        next();
        idle(); use_rs1 = 1'b1; rs1_addr = 5'd7; use_rs2 = 1'b1; rs2_addr = 5'd7;
        mid();
        check("prio_rs1", rs1_fw, 32'h2);
        check("prio_rs2", rs2_fw, 32'h2);
        next();
        idle(); use_rs1 = 1'b1; rs1_addr = 5'd7;
        mid();
        check("prio_age1", rs1_fw, 32'h2);
        next();
        idle(); use_rs1 = 1'b1; rs1_addr = 5'd7;
        mid();
        check("prio_aged_out", rs1_fw, 32'hA1A1A1A1);
        next();

        // independent matches to different entries
        idle(); wr(5'd10, 32'h0000AAAA);
        next();
        idle(); wr(5'd11, 32'h0000BBBB);
        next();
        idle(); use_rs1 = 1'b1; rs1_addr = 5'd10; use_rs2 = 1'b1; rs2_addr = 5'd11;
        mid();
        check("indep_rs1", rs1_fw, 32'h0000AAAA);
        check("indep_rs2", rs2_fw, 32'h0000BBBB);
        next();

        // x0 write and unused operand
        idle(); wr(5'd0, 32'hFF);
        next();
        idle(); use_rs1 = 1'b1; rs1_addr = 5'd0;
        mid();
        check("x0_nofwd", rs1_fw, 32'hA1A1A1A1);
        next();
        idle(); wr(5'd12, 32'h12);
        next();
        idle(); use_rs1 = 1'b0; rs1_addr = 5'd12;
        mid();
        check("unused_nofwd", rs1_fw, 32'hA1A1A1A1);
        next();

        // redirect, with a squashed writer in EX
        idle(); redirect = 1'b1;
        mid();
        check("redir_pre", {28'd0, squash}, 32'h0);
        next();
        idle(); wr(5'd8, 32'h88);
        mid();
        check("redir_sq1", {28'd0, squash}, 32'h3);
        next();
        idle(); use_rs1 = 1'b1; rs1_addr = 5'd8;
        mid();
        check("redir_sq2", {28'd0, squash}, 32'h6);
        check("squashed_wr", rs1_fw, 32'hA1A1A1A1);
        next();
        idle();
        next(); next(); next();
        mid();
        check("redir_drain", {28'd0, squash}, 32'h0);

        // flush
        next();
        idle(); flush = 1'b1;
        next();
        idle();
        mid();
        check("flush_sq1", {28'd0, squash}, 32'h1);
        next();
        mid();
        check("flush_sq2", {28'd0, squash}, 32'h2);
        next(); next(); next();

        // load-use, both operands, redirect in the stall cycle
        idle(); wr(5'd6, 32'h600); ex_is_load = 1'b1;
        next();
        idle(); use_rs1 = 1'b1; rs1_addr = 5'd6; use_rs2 = 1'b1; rs2_addr = 5'd6; redirect = 1'b1;
        mid();
        check("lu_stall", {31'd0, stall_n}, 32'h0);
        next();
        idle(); use_rs1 = 1'b1; rs1_addr = 5'd6; use_rs2 = 1'b1; rs2_addr = 5'd6;
        mem_load_data = 32'hDEADBEEF;
        mid();
        check("lu_release", {31'd0, stall_n}, 32'h1);
        check("lu_squash", {28'd0, squash}, 32'h4);
        check("lu_rs1", rs1_fw, 32'hDEADBEEF);
        check("lu_rs2", rs2_fw, 32'hDEADBEEF);
        next();
        idle();
        mid();
        check("lu_squash_shift", {28'd0, squash}, 32'h8);
        next();

        // LOAD_LAT=2 instance: two stall cycles
        idle(); RST = 1'b1;
        next();
        RST = 1'b0;
        idle(); wr(5'd6, 32'h600); ex_is_load = 1'b1;
        next();
        idle(); use_rs2 = 1'b1; rs2_addr = 5'd6;
        mid();
        check("lat2_stall1", {31'd0, stall_n_b}, 32'h0);
        next();
        idle(); use_rs2 = 1'b1; rs2_addr = 5'd6; mem_load_data = 32'h11111111;
        mid();
        check("lat2_stall2", {31'd0, stall_n_b}, 32'h0);
        check("lat1_released", {31'd0, stall_n}, 32'h1);
        next();
        idle(); use_rs2 = 1'b1; rs2_addr = 5'd6; mem_load_data = 32'hCAFEF00D;
        mid();
        check("lat2_release", {31'd0, stall_n_b}, 32'h1);
        check("lat2_fwd", rs2_fw_b, 32'hCAFEF00D);
        check("lat2_squash", {28'd0, squash_b}, 32'hC);
        next();
        idle();
        next(); next(); next(); next();

        // reset in the middle of a stall
        idle(); wr(5'd6, 32'h600); ex_is_load = 1'b1;
        next();
        idle(); use_rs2 = 1'b1; rs2_addr = 5'd6; mem_load_data = 32'h77777777;
        mid();
        check("rst_pre_stall", {31'd0, stall_n}, 32'h0);
        RST = 1'b1;
        #1;
        check("rst_stall_n", {31'd0, stall_n}, 32'h1);
        check("rst_pass", rs2_fw, 32'hB2B2B2B2);
        next();
        RST = 1'b0;
        mid();
        check("rst_after_squash", {28'd0, squash}, 32'h0);
        check("rst_after_stall_n", {31'd0, stall_n}, 32'h1);
        check("rst_after_pass", rs2_fw, 32'hB2B2B2B2);
`ifdef HAZ_PERF_EN
        check("perf_stall_clr", perf_stall_cnt, 32'h0);
        check("perf_fwd_clr", perf_fwd_cnt, 32'h0);
`endif
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit_param.md
Name: hazard_unit_param

Overview:
- Parametrised forwarding, load-use stall and squash controller for the pipelined Otter core. Next generation of the fixed two-deep hazard block.
- Tracks the last FWD_DEPTH register writers leaving EX in a shift table.
- Forwards ALU, CSR and load results to the operands entering EX.
- Stalls for a configurable load latency and drives an NSTAGE-wide squash shift register.

Parameters:
- XLEN, 32, datapath width.
- FWD_DEPTH, 2, tracked writer entries; entry 0 is newest; must be > LOAD_LAT.
- LOAD_LAT, 1, table index at which load data appears on mem_load_data; range 1..3.
- NSTAGE, 4, squash bits; bit0=DE, bit1=EX, bit2=MEM, bit3=WB, higher bits are extra stages.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- ex_reg_write  in  1  instruction in EX writes rd.
- ex_wr_addr  in  5  rd of the EX instruction.
- ex_is_load  in  1  EX instruction is a LOAD.
- ex_csr_en  in  1  EX instruction is a CSR op; rd takes csr_out.
- ex_alu_out  in  XLEN  ALU result.
- ex_csr_out  in  XLEN  CSR read value.
- mem_load_data  in  XLEN  load data for the table entry at index LOAD_LAT.
- use_rs1, use_rs2  in  1 each  operand is sourced from the register file.
- rs1_addr, rs2_addr  in  5 each  source register numbers.
- rs1_data, rs2_data  in  XLEN each  register-file values.
- redirect  in  1  PC change (branch taken, jump, mret).
- flush  in  1  trap flush request for DE.
- rs1_fw, rs2_fw  out  XLEN each  forwarded operands.
- stall_n  out  1  active-low stall of PC, IF, DE and EX.
- squash  out  NSTAGE  per-stage squash, registered.

Behaviour:
- Clocking and reset: single CLK; RST is synchronous and active-high.
- Reset effect: RST clears all table entries to invalid and sets squash to 0. RST overrides every other input.
- During RST and the cycle after: stall_n=1, rs*_fw=rs*_data.
- Table entry fields: valid, addr[4:0], is_load, data[XLEN-1:0].
- Table update: every cycle, entry i+1 <= entry i; the oldest entry drops out.
- New entry 0, when stall_n=1: valid = ex_reg_write & (ex_wr_addr!=0) & ~squash[1].
  - data = ex_csr_en ? ex_csr_out : ex_alu_out.
  - is_load = ex_is_load & ~ex_csr_en.
- New entry 0, when stall_n=0: a bubble is inserted (valid=0); older entries still shift.
- Load capture: when entry LOAD_LAT is a valid load, it shifts into LOAD_LAT+1 with data=mem_load_data and is_load=0.
- Operand match: rsX matches entry i when useX=1, entry valid, addr==rsX_addr and rsX_addr!=0. The lowest matching index wins (youngest writer). No match gives rsX_fw=rsX_data.
- Per winning entry i:
  - Not a load: forward entry data.
  - Load with i==LOAD_LAT: forward mem_load_data.
  - Load with i<LOAD_LAT: hazard.
  - Load with i>LOAD_LAT cannot occur (already converted).
- stall_n = ~(hazard on rs1 | hazard on rs2), combinational.
- Stall duration: stall_n is held low each cycle until the load reaches LOAD_LAT. Stall length = LOAD_LAT - i cycles, so a back-to-back load-use costs LOAD_LAT cycles.
- Squash, default: squash_next = squash<<1 (bit0 fills with 0).
- Squash, stall_n=0: squash_next[1:0] = squash[1:0] (held) and squash_next[2]=1 (bubble into MEM). Upper bits still shift.
- Squash, redirect & stall_n=1: squash_next[1:0] = 2'b11.
- Squash, flush & stall_n=1: squash_next[0] = 1.
- Simultaneous events: redirect or flush during a stall is ignored. The holding instruction re-asserts it after the stall.
- Squashed writers: an EX instruction with squash[1]=1 never enters the table, even when ex_reg_write=1.
- Both operands hazarding give a single stall.
- Simultaneous rs1 and rs2 matches to different entries are resolved independently.
- Reset mid-stall aborts the stall: table invalid, stall_n=1 next cycle.

Optional Feature:
- Macro HAZ_PERF_EN.
- When defined: adds outputs perf_stall_cnt[31:0] (cycles with stall_n=0) and perf_fwd_cnt[31:0] (cycles with any forward taken).
  - Both counters increment by 1 per qualifying cycle, wrap at 2^32 and clear on RST.
- When undefined: no such ports, no counter logic; all other behaviour is identical.

Test Plan:
- ALU chain: EX writes x5=0x00001234; next cycle use_rs1=1, rs1_addr=5 -> rs1_fw=0x00001234, stall_n=1.
- Load-use, LOAD_LAT=1:
  - Stimulus: load x6, next cycle use_rs2=1, rs2_addr=6, then mem_load_data=0xDEADBEEF.
  - Required: stall_n=0 for exactly 1 cycle; squash[2]=1 the next cycle with squash[1:0] held; then rs2_fw=0xDEADBEEF.
  - Rerun with LOAD_LAT=2, FWD_DEPTH=3 -> exactly 2 stall cycles.
- Priority: x7=0x1 then x7=0x2 on consecutive cycles; read x7 -> 0x2. With FWD_DEPTH=2, three cycles later -> rs1_data.
- x0 and squashed writes:
  - EX writes x0=0xFF, then read x0 -> rs1_data.
  - Write x8 with squash[1]=1, then read x8 -> rs1_data.
- Redirect:
  - squash=0000 and redirect=1 with no stall -> squash=0011, then 0110.
  - redirect and a load-use hazard in the same cycle -> squash[1:0] unchanged.
- Reset mid-stall: assert RST while stall_n=0 -> next cycle squash=0000, stall_n=1, outputs pass through.
  - With HAZ_PERF_EN defined, both counters read 0.
